// File: rtl/frame_scheduler.sv
// Per-frame sequencer: on each accepted end-of-frame pulse, starts NUM_STAGES
// engines one after another and waits for each done (or a timeout) in turn.
module frame_scheduler #(
   parameter int NUM_STAGES    = 4,
   parameter int STAGE_TIMEOUT = 65536,
   parameter int FRAME_CNT_W   = 16
) (
   input  logic                   pixel_clock,
   input  logic                   rst_n,
   input  logic                   frame_irq,
   input  logic                   enable,
   input  logic [NUM_STAGES-1:0]  done,
   input  logic                   clear_flags,
   output logic [NUM_STAGES-1:0]  start,
   output logic [2:0]             stage,
   output logic                   busy,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   overrun,
   output logic [7:0]             overrun_count,
   output logic                   timeout
);

   localparam int                 TIMER_W    = $clog2(STAGE_TIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STAGE_TIMEOUT - 1);
   localparam logic [2:0]         LAST_STAGE = 3'(NUM_STAGES - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t                  state, next_state;
   logic [2:0]              next_stage;
   logic [TIMER_W-1:0]      timer;
   logic [NUM_STAGES-1:0]   start_next;
   logic                    stage_done;
   logic                    frame_end;
   logic                    timeout_set;
   logic                    overrun_set;

   assign busy        = (state != IDLE);
   assign overrun_set = frame_irq && (state != IDLE);

   // Only the done bit of the engine currently being waited on matters.
   always_comb begin
      stage_done = 1'b0;
      start_next = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         if (stage == 3'(k)) stage_done = done[k];
         if (next_stage == 3'(k)) start_next[k] = 1'b1;
      end
   end

   always_comb begin
      next_state  = state;
      next_stage  = stage;
      frame_end   = 1'b0;
      timeout_set = 1'b0;
      case (state)
         IDLE: begin
            if (frame_irq && enable) begin
               next_state = START;
               next_stage = 3'd0;
            end
         end
         START: next_state = WAIT;
         WAIT: begin
            // A timed-out stage is skipped exactly as if its engine had answered.
            if (stage_done || (timer == TIMER_LAST)) begin
               timeout_set = !stage_done;
               if (stage == LAST_STAGE) begin
                  next_state = IDLE;
                  frame_end  = 1'b1;
               end else begin
                  next_state = START;
                  next_stage = stage + 3'd1;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clock or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         stage         <= 3'd0;
         start         <= '0;
         timer         <= '0;
         frame_count   <= '0;
         overrun       <= 1'b0;
         overrun_count <= 8'd0;
         timeout       <= 1'b0;
      end else begin
         state <= next_state;
         stage <= next_stage;
         start <= (next_state == START) ? start_next : '0;
         if (state == START)
            timer <= '0;
         else if (state == WAIT)
            timer <= timer + TIMER_W'(1);
         if (frame_end)
            frame_count <= frame_count + FRAME_CNT_W'(1);
         // Sticky flags: a same-cycle set beats clear_flags.
         overrun <= overrun_set | (overrun & ~clear_flags);
         timeout <= timeout_set | (timeout & ~clear_flags);
         if (overrun_set && (overrun_count != 8'hFF))
            overrun_count <= overrun_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: expected start pulses go into a
// scoreboard queue and are matched against the DUT as they appear.
module tb_frame_scheduler;

   localparam int NS = 4;
   localparam int TO = 16;
   localparam int FW = 8;

   logic          pixel_clock = 1'b0;
   logic          rst_n       = 1'b1;
   logic          frame_irq   = 1'b0;
   logic          enable      = 1'b0;
   logic          clear_flags = 1'b0;
   logic [NS-1:0] done        = '0;
   logic [NS-1:0] start;
   logic [2:0]    stage;
   logic          busy;
   logic [FW-1:0] frame_count;
   logic          overrun;
   logic [7:0]    overrun_count;
   logic          timeout;

   frame_scheduler #(
      .NUM_STAGES(NS), .STAGE_TIMEOUT(TO), .FRAME_CNT_W(FW)
   ) dut (
      .pixel_clock(pixel_clock), .rst_n(rst_n), .frame_irq(frame_irq),
      .enable(enable), .done(done), .clear_flags(clear_flags),
      .start(start), .stage(stage), .busy(busy), .frame_count(frame_count),
      .overrun(overrun), .overrun_count(overrun_count), .timeout(timeout)
   );

   always #5 pixel_clock = ~pixel_clock;

   typedef struct {
      int            c;
      logic [NS-1:0] v;
   } exp_t;

   exp_t exp_q[$];
   exp_t got_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   lat[NS];
   int   pend[NS];

   // Scoreboard monitor: every start pulse must match the oldest expectation.
   always @(negedge pixel_clock) begin
      if (rst_n && (start !== '0)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL start_unexpected: cycle %0d start=%b, required no pulse", cyc, start);
         end else begin
            got_e = exp_q.pop_front();
            if ((got_e.c != cyc) || (got_e.v !== start)) begin
               failures++;
               $display("FAIL start_pulse: cycle %0d start=%b, required cycle %0d start=%b",
                        cyc, start, got_e.c, got_e.v);
            end
         end
      end
   end

   task automatic expect_start(input int c, input int k);
      exp_t e;
      e.c    = c;
      e.v    = '0;
      e.v[k] = 1'b1;
      exp_q.push_back(e);
   endtask

   // Advance one cycle; engines with nonzero latency answer lat cycles after start.
   task automatic step();
      @(posedge pixel_clock);
      #1;
      cyc++;
      for (int k = 0; k < NS; k++) begin
         if (start[k] && lat[k] > 0) pend[k] = cyc + lat[k];
         done[k] = (pend[k] == cyc);
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      step();
      step();
      checks++; if (start !== '0) begin failures++; $display("FAIL reset_start: got %b, want 0", start); end
      checks++; if (stage !== 3'd0) begin failures++; $display("FAIL reset_stage: got %0d, want 0", stage); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, want 0", busy); end
      checks++; if (frame_count !== '0) begin failures++; $display("FAIL reset_frame_count: got %0d, want 0", frame_count); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b, want 0", overrun); end
      checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL reset_overrun_count: got %0d, want 0", overrun_count); end
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b, want 0", timeout); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int t;
      lat    = '{1, 1, 1, 1};
      enable = 1'b1;
      t      = cyc;
      for (int k = 0; k < NS; k++) expect_start(t + 1 + 2 * k, k);
      frame_irq = 1'b1;
      step();
      frame_irq = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_high: got %b, want 1", busy); end
      while (cyc < t + 9) step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_low: got %b, want 0", busy); end
      checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL basic_frame_count: got %0d, want 1", frame_count); end
      checks++; if (stage !== 3'd3) begin failures++; $display("FAIL basic_stage_hold: got %0d, want 3", stage); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_enable_gate();
      int t;
      enable    = 1'b0;
      frame_irq = 1'b1;
      step();
      frame_irq = 1'b0;
      step();
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL gate_busy: got %b, want 0", busy); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL gate_overrun: got %b, want 0", overrun); end
      enable = 1'b1;
      t      = cyc;
      for (int k = 0; k < NS; k++) expect_start(t + 1 + 2 * k, k);
      frame_irq = 1'b1;
      step();
      frame_irq = 1'b0;
      while (cyc < t + 9) step();
      checks++; if (frame_count !== FW'(2)) begin failures++; $display("FAIL gate_frame_count: got %0d, want 2", frame_count); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL gate_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_overrun();
      int t;
      lat = '{1, 1, 6, 1};
      t   = cyc;
      expect_start(t + 1, 0);
      expect_start(t + 3, 1);
      expect_start(t + 5, 2);
      expect_start(t + 12, 3);
      frame_irq = 1'b1;
      step();
      while (cyc < t + 14) begin
         if (cyc == t + 8) begin
            checks++; if (stage !== 3'd2) begin failures++; $display("FAIL overrun_stage: got %0d, want 2", stage); end
         end
         frame_irq   = (cyc == t + 7) || (cyc == t + 9) || (cyc == t + 13);
         clear_flags = (cyc == t + 13);
         step();
      end
      frame_irq   = 1'b0;
      clear_flags = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag_set_wins: got %b, want 1", overrun); end
      checks++; if (overrun_count !== 8'd3) begin failures++; $display("FAIL overrun_count: got %0d, want 3", overrun_count); end
      checks++; if (frame_count !== FW'(3)) begin failures++; $display("FAIL overrun_frame_count: got %0d, want 3", frame_count); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL overrun_busy: got %b, want 0", busy); end
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear: got %b, want 0", overrun); end
      checks++; if (overrun_count !== 8'd3) begin failures++; $display("FAIL overrun_count_kept: got %0d, want 3", overrun_count); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL overrun_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int t;
      lat = '{1, 1, 1, 1};
      t   = cyc;
      for (int k = 0; k < NS; k++) expect_start(t + 1 + 2 * k, k);
      for (int k = 0; k < NS; k++) expect_start(t + 10 + 2 * k, k);
      while (cyc < t + 18) begin
         if (cyc == t + 9) begin
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy: got %b, want 0", busy); end
         end
         frame_irq = (cyc == t) || (cyc == t + 9);
         step();
      end
      frame_irq = 1'b0;
      checks++; if (frame_count !== FW'(5)) begin failures++; $display("FAIL b2b_frame_count: got %0d, want 5", frame_count); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun: got %b, want 0", overrun); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      int t;
      lat = '{1, 0, 1, 1};
      t   = cyc;
      expect_start(t + 1, 0);
      expect_start(t + 3, 1);
      expect_start(t + 3 + TO + 1, 2);
      expect_start(t + 3 + TO + 3, 3);
      while (cyc < t + 3 + TO + 5) begin
         if (cyc == t + 3 + TO) begin
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b, want 0", timeout); end
            checks++; if (stage !== 3'd1) begin failures++; $display("FAIL timeout_stage: got %0d, want 1", stage); end
         end
         if (cyc == t + 3 + TO + 1) begin
            checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_set: got %b, want 1", timeout); end
         end
         frame_irq = (cyc == t);
         step();
         if (cyc == t + 8) done[3] = 1'b1;
      end
      frame_irq = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b, want 0", busy); end
      checks++; if (frame_count !== FW'(6)) begin failures++; $display("FAIL timeout_frame_count: got %0d, want 6", frame_count); end
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear: got %b, want 0", timeout); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL timeout_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midframe();
      int t;
      lat = '{1, 1, 0, 1};
      t   = cyc;
      expect_start(t + 1, 0);
      expect_start(t + 3, 1);
      expect_start(t + 5, 2);
      frame_irq = 1'b1;
      step();
      frame_irq = 1'b0;
      while (cyc < t + 7) step();
      rst_n = 1'b0;
      #1;
      checks++; if (start !== '0) begin failures++; $display("FAIL midreset_start: got %b, want 0", start); end
      checks++; if (stage !== 3'd0) begin failures++; $display("FAIL midreset_stage: got %0d, want 0", stage); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b, want 0", busy); end
      checks++; if (frame_count !== '0) begin failures++; $display("FAIL midreset_frame_count: got %0d, want 0", frame_count); end
      checks++; if (overrun_count !== 8'd0) begin failures++; $display("FAIL midreset_overrun_count: got %0d, want 0", overrun_count); end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_missing_starts: %0d left, want 0", exp_q.size()); end
      lat = '{1, 1, 1, 1};
      t   = cyc;
      for (int k = 0; k < NS; k++) expect_start(t + 1 + 2 * k, k);
      frame_irq = 1'b1;
      step();
      frame_irq = 1'b0;
      while (cyc < t + 9) step();
      checks++; if (frame_count !== FW'(1)) begin failures++; $display("FAIL midreset_restart_count: got %0d, want 1", frame_count); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_restart_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      int t;
      lat = '{1, 1, 1, 1};
      for (int f = 0; f < 255; f++) begin
         if (f == 254) begin
            checks++; if (frame_count !== FW'(255)) begin failures++; $display("FAIL wrap_pre: got %0d, want 255", frame_count); end
         end
         t = cyc;
         for (int k = 0; k < NS; k++) expect_start(t + 1 + 2 * k, k);
         frame_irq = 1'b1;
         step();
         frame_irq = 1'b0;
         while (cyc < t + 9) step();
      end
      checks++; if (frame_count !== FW'(0)) begin failures++; $display("FAIL wrap_zero: got %0d, want 0", frame_count); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   task automatic test_saturate();
      int t;
      int flen;
      lat  = '{0, 0, 0, 0};
      flen = NS * (TO + 1) + 1;
      t    = cyc;
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < NS; k++)
            expect_start(t + flen * f + 1 + (TO + 1) * k, k);
      while (cyc < t + 4 * flen + 1) begin
         if (cyc == t + 3 * flen) begin
            checks++; if (overrun_count !== 8'd204) begin failures++; $display("FAIL sat_partial: got %0d, want 204", overrun_count); end
            checks++; if (frame_count !== FW'(3)) begin failures++; $display("FAIL sat_partial_frames: got %0d, want 3", frame_count); end
         end
         frame_irq = (cyc < t + 4 * flen);
         step();
      end
      frame_irq = 1'b0;
      checks++; if (overrun_count !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d, want 255", overrun_count); end
      checks++; if (frame_count !== FW'(4)) begin failures++; $display("FAIL sat_frames: got %0d, want 4", frame_count); end
      checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL sat_timeout: got %b, want 1", timeout); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sat_busy: got %b, want 0", busy); end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sat_missing_starts: %0d left, want 0", exp_q.size()); end
   endtask

   initial begin
      for (int k = 0; k < NS; k++) begin
         pend[k] = -1;
         lat[k]  = 1;
      end
      test_reset();
      test_basic();
      test_enable_gate();
      test_overrun();
      test_back_to_back();
      test_timeout();
      test_reset_midframe();
      test_wrap();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
